// File: rtl/rom_region_loader.sv
// Splits a ROM download byte stream across fixed regions, writing each region
// either byte-wise into a BRAM or as 16-bit words into SDRAM.
module rom_region_loader #(
  parameter int N_REGIONS = 9,
  parameter int ADDR_W = 25,
  parameter int CS_W = 6,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*24-1:0] REGION_SIZE = {N_REGIONS{24'h010000}},
  parameter logic [N_REGIONS-1:0] REGION_REORDER = '0,
  parameter logic [N_REGIONS*CS_W-1:0] REGION_CS = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              bram_wr,
  output logic [CS_W-1:0]   bram_cs,
  output logic [23:0]       bram_addr,
  output logic [7:0]        bram_data,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [15:0]       sdr_data,
  output logic [1:0]        sdr_be,
  output logic [3:0]        region_idx,
  output logic              load_done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, SDR_WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              dl_prev_reg;
  logic [3:0]        region_idx_reg, region_idx_next;
  logic [23:0]       offset_reg, offset_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [7:0]        pend_byte_reg, pend_byte_next;
  logic              finish_reg, finish_next;
  logic              load_done_reg, load_done_next;
  logic              overflow_reg, overflow_next;
  logic              bram_wr_reg, bram_wr_next;
  logic [CS_W-1:0]   bram_cs_reg, bram_cs_next;
  logic [23:0]       bram_addr_reg, bram_addr_next;
  logic [7:0]        bram_data_reg, bram_data_next;
  logic [ADDR_W-1:0] sdr_addr_reg, sdr_addr_next;
  logic [15:0]       sdr_data_reg, sdr_data_next;
  logic [1:0]        sdr_be_reg, sdr_be_next;

  // Region attributes unpacked into 16-entry tables so the 4-bit index never
  // leaves the array, whatever N_REGIONS is.
  logic [ADDR_W-1:0] base_tab    [16];
  logic [23:0]       size_tab    [16];
  logic              reorder_tab [16];
  logic [CS_W-1:0]   cs_tab      [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_tab
      if (gi < N_REGIONS) begin : g_used
        assign base_tab[gi]    = REGION_BASE[gi*ADDR_W +: ADDR_W];
        assign size_tab[gi]    = REGION_SIZE[gi*24 +: 24];
        assign reorder_tab[gi] = REGION_REORDER[gi];
        assign cs_tab[gi]      = REGION_CS[gi*CS_W +: CS_W];
      end else begin : g_unused
        assign base_tab[gi]    = '0;
        assign size_tab[gi]    = 24'd1;
        assign reorder_tab[gi] = 1'b0;
        assign cs_tab[gi]      = '0;
      end
    end
  endgenerate

  logic [ADDR_W-1:0] cur_base;
  logic [23:0]       cur_size;
  logic              cur_reorder;
  logic [CS_W-1:0]   cur_cs;
  logic              is_bram, is_last, at_close, dl_rise;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        solo_byte;
  logic [15:0]       word_data, solo_data;
  logic [1:0]        solo_be;

  assign cur_base    = base_tab[region_idx_reg];
  assign cur_size    = size_tab[region_idx_reg];
  assign cur_reorder = reorder_tab[region_idx_reg];
  assign cur_cs      = cs_tab[region_idx_reg];
  assign is_bram     = |cur_cs;
  assign is_last     = (region_idx_reg == 4'(N_REGIONS - 1));
  assign at_close    = (offset_reg == cur_size - 24'd1);
  assign dl_rise     = ioctl_download & ~dl_prev_reg;

  // Word address of the 16-bit slot holding the current offset; for an odd
  // offset this is offset-1, for an even one the offset itself.
  assign word_addr = cur_base + ADDR_W'({offset_reg[23:1], 1'b0});
  assign word_data = cur_reorder ? {pend_byte_reg, ioctl_dout} : {ioctl_dout, pend_byte_reg};
  // A lone byte is either the closing byte of an odd-sized region or a
  // pending byte flushed when the download ends early.
  assign solo_byte = ioctl_wr ? ioctl_dout : pend_byte_reg;
  assign solo_data = cur_reorder ? {solo_byte, 8'h00} : {8'h00, solo_byte};
  assign solo_be   = cur_reorder ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      dl_prev_reg    <= 1'b0;
      region_idx_reg <= '0;
      offset_reg     <= '0;
      pend_valid_reg <= 1'b0;
      pend_byte_reg  <= '0;
      finish_reg     <= 1'b0;
      load_done_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      bram_wr_reg    <= 1'b0;
      bram_cs_reg    <= '0;
      bram_addr_reg  <= '0;
      bram_data_reg  <= '0;
      sdr_addr_reg   <= '0;
      sdr_data_reg   <= '0;
      sdr_be_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      dl_prev_reg    <= ioctl_download;
      region_idx_reg <= region_idx_next;
      offset_reg     <= offset_next;
      pend_valid_reg <= pend_valid_next;
      pend_byte_reg  <= pend_byte_next;
      finish_reg     <= finish_next;
      load_done_reg  <= load_done_next;
      overflow_reg   <= overflow_next;
      bram_wr_reg    <= bram_wr_next;
      bram_cs_reg    <= bram_cs_next;
      bram_addr_reg  <= bram_addr_next;
      bram_data_reg  <= bram_data_next;
      sdr_addr_reg   <= sdr_addr_next;
      sdr_data_reg   <= sdr_data_next;
      sdr_be_reg     <= sdr_be_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    region_idx_next = region_idx_reg;
    offset_next     = offset_reg;
    pend_valid_next = pend_valid_reg;
    pend_byte_next  = pend_byte_reg;
    finish_next     = finish_reg;
    load_done_next  = load_done_reg;
    overflow_next   = overflow_reg;
    bram_wr_next    = 1'b0;
    bram_cs_next    = bram_cs_reg;
    bram_addr_next  = bram_addr_reg;
    bram_data_next  = bram_data_reg;
    sdr_addr_next   = sdr_addr_reg;
    sdr_data_next   = sdr_data_reg;
    sdr_be_next     = sdr_be_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (dl_rise) begin
          state_next      = LOAD;
          region_idx_next = '0;
          offset_next     = '0;
          pend_valid_next = 1'b0;
          pend_byte_next  = '0;
          finish_next     = 1'b0;
          load_done_next  = 1'b0;
          overflow_next   = 1'b0;
        end else if (state_reg == DONE && ioctl_wr) begin
          overflow_next = 1'b1;
        end
      end

      LOAD: begin
        if (ioctl_wr) begin
          offset_next = at_close ? 24'd0 : offset_reg + 24'd1;
          if (at_close && !is_last)
            region_idx_next = region_idx_reg + 4'd1;
          if (is_bram) begin
            bram_wr_next   = 1'b1;
            bram_cs_next   = cur_cs;
            bram_addr_next = offset_reg;
            bram_data_next = ioctl_dout;
            if (at_close && is_last) begin
              state_next     = DONE;
              load_done_next = 1'b1;
            end
          end else if (!offset_reg[0]) begin
            if (at_close) begin
              sdr_addr_next = word_addr;
              sdr_data_next = solo_data;
              sdr_be_next   = solo_be;
              finish_next   = is_last;
              state_next    = SDR_WAIT;
            end else begin
              pend_valid_next = 1'b1;
              pend_byte_next  = ioctl_dout;
            end
          end else begin
            sdr_addr_next   = word_addr;
            sdr_data_next   = word_data;
            sdr_be_next     = 2'b11;
            pend_valid_next = 1'b0;
            finish_next     = at_close && is_last;
            state_next      = SDR_WAIT;
          end
        end else if (!ioctl_download) begin
          if (pend_valid_reg) begin
            sdr_addr_next   = word_addr;
            sdr_data_next   = solo_data;
            sdr_be_next     = solo_be;
            pend_valid_next = 1'b0;
            finish_next     = 1'b1;
            state_next      = SDR_WAIT;
          end else begin
            state_next     = DONE;
            load_done_next = 1'b1;
          end
        end
      end

      SDR_WAIT: begin
        // Strobes arriving here are stalled by ioctl_wait and dropped.
        if (sdr_ack) begin
          if (finish_reg || !ioctl_download) begin
            state_next     = DONE;
            load_done_next = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign ioctl_wait = (state_reg == SDR_WAIT);
  assign sdr_req    = (state_reg == SDR_WAIT);
  assign bram_wr    = bram_wr_reg;
  assign bram_cs    = bram_cs_reg;
  assign bram_addr  = bram_addr_reg;
  assign bram_data  = bram_data_reg;
  assign sdr_addr   = sdr_addr_reg;
  assign sdr_data   = sdr_data_reg;
  assign sdr_be     = sdr_be_reg;
  assign region_idx = region_idx_reg;
  assign load_done  = load_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_rom_region_loader.sv
// Directed bench for rom_region_loader: three parameterisations share the
// download stimulus; only the selected instance's writes are recorded.
module tb_rom_region_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       ioctl_download = 1'b0;
  logic       ioctl_wr = 1'b0;
  logic [7:0] ioctl_dout = 8'h00;

  logic        wait_v      [3];
  logic        bram_wr_v   [3];
  logic [5:0]  bram_cs_v   [3];
  logic [23:0] bram_addr_v [3];
  logic [7:0]  bram_data_v [3];
  logic        req_v       [3];
  logic        ack_v       [3];
  logic [24:0] sdr_addr_v  [3];
  logic [15:0] sdr_data_v  [3];
  logic [1:0]  sdr_be_v    [3];
  logic [3:0]  idx_v       [3];
  logic        done_v      [3];
  logic        ovf_v       [3];

  int ack_dly [3];
  int ack_cnt [3];
  int sel = 0;
  int total = 0;
  int bad = 0;

  // Instance 0: region0 BRAM (cs 1, 4 bytes), remaining 8 regions default.
  rom_region_loader #(
    .REGION_SIZE ({{8{24'h010000}}, 24'd4}),
    .REGION_CS   ({{8{6'd0}}, 6'b000001})
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait_v[0]), .bram_wr(bram_wr_v[0]), .bram_cs(bram_cs_v[0]),
    .bram_addr(bram_addr_v[0]), .bram_data(bram_data_v[0]), .sdr_req(req_v[0]), .sdr_ack(ack_v[0]),
    .sdr_addr(sdr_addr_v[0]), .sdr_data(sdr_data_v[0]), .sdr_be(sdr_be_v[0]),
    .region_idx(idx_v[0]), .load_done(done_v[0]), .overflow(ovf_v[0])
  );

  // Instance 1: region0 SDRAM at 'h40000 size 3, region1 BRAM cs 2 size 2.
  rom_region_loader #(
    .N_REGIONS      (2),
    .REGION_BASE    ({25'd0, 25'h40000}),
    .REGION_SIZE    ({24'd2, 24'd3}),
    .REGION_REORDER (2'b00),
    .REGION_CS      ({6'd2, 6'd0})
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait_v[1]), .bram_wr(bram_wr_v[1]), .bram_cs(bram_cs_v[1]),
    .bram_addr(bram_addr_v[1]), .bram_data(bram_data_v[1]), .sdr_req(req_v[1]), .sdr_ack(ack_v[1]),
    .sdr_addr(sdr_addr_v[1]), .sdr_data(sdr_data_v[1]), .sdr_be(sdr_be_v[1]),
    .region_idx(idx_v[1]), .load_done(done_v[1]), .overflow(ovf_v[1])
  );

  // Instance 2: single byte-swapped SDRAM region at 'h40000, size 3.
  rom_region_loader #(
    .N_REGIONS      (1),
    .REGION_BASE    (25'h40000),
    .REGION_SIZE    (24'd3),
    .REGION_REORDER (1'b1),
    .REGION_CS      (6'd0)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait_v[2]), .bram_wr(bram_wr_v[2]), .bram_cs(bram_cs_v[2]),
    .bram_addr(bram_addr_v[2]), .bram_data(bram_data_v[2]), .sdr_req(req_v[2]), .sdr_ack(ack_v[2]),
    .sdr_addr(sdr_addr_v[2]), .sdr_data(sdr_data_v[2]), .sdr_be(sdr_be_v[2]),
    .region_idx(idx_v[2]), .load_done(done_v[2]), .overflow(ovf_v[2])
  );

  // SDRAM responder: one-cycle ack after ack_dly cycles of sdr_req.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset_n || ack_v[d]) begin
        ack_v[d]   <= 1'b0;
        ack_cnt[d] <= 0;
      end else if (req_v[d]) begin
        if (ack_cnt[d] >= ack_dly[d]) ack_v[d] <= 1'b1;
        else ack_cnt[d] <= ack_cnt[d] + 1;
      end else begin
        ack_cnt[d] <= 0;
      end
    end
  end

  typedef struct packed {
    logic        kind;   // 0 = BRAM byte, 1 = SDRAM word
    logic [31:0] addr;
    logic [15:0] data;
    logic [7:0]  tag;    // bram_cs or sdr_be
  } wr_t;

  wr_t q[$];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (d == sel && bram_wr_v[d])
        q.push_back(wr_t'{1'b0, 32'(bram_addr_v[d]), {8'h00, bram_data_v[d]}, {2'b00, bram_cs_v[d]}});
      if (d == sel && req_v[d] && ack_v[d])
        q.push_back(wr_t'{1'b1, 32'(sdr_addr_v[d]), sdr_data_v[d], {6'd0, sdr_be_v[d]}});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic restart_all(input int s);
    sel = s;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    @(negedge clk);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    int n;
    @(negedge clk);
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    n = 0;
    while (wait_v[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_released", 64'(wait_v[d]), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_write(input string name, input wr_t exp);
    wr_t r;
    chk({name, "_count"}, 64'(q.size()), 64'd1);
    if (q.size() > 0) begin
      r = q.pop_front();
      chk(name, 64'(r), 64'(exp));
    end
    q.delete();
  endtask

  typedef struct packed {
    logic        start;
    logic [1:0]  d;
    logic [7:0]  byte_in;
    logic        exp_w;
    wr_t         w;
    logic [3:0]  idx;
    logic        done;
    logic        ovf;
  } vec_t;

  vec_t vec [14];

  initial begin
    vec[0]  = '{1'b1, 2'd0, 8'h11, 1'b1, wr_t'{1'b0, 32'd0, 16'h0011, 8'h01}, 4'd0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 2'd0, 8'h22, 1'b1, wr_t'{1'b0, 32'd1, 16'h0022, 8'h01}, 4'd0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 2'd0, 8'h33, 1'b1, wr_t'{1'b0, 32'd2, 16'h0033, 8'h01}, 4'd0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 2'd0, 8'h44, 1'b1, wr_t'{1'b0, 32'd3, 16'h0044, 8'h01}, 4'd1, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 2'd1, 8'h01, 1'b0, wr_t'('0), 4'd0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 2'd1, 8'h02, 1'b1, wr_t'{1'b1, 32'h40000, 16'h0201, 8'h03}, 4'd0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 2'd1, 8'h03, 1'b1, wr_t'{1'b1, 32'h40002, 16'h0003, 8'h01}, 4'd1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 2'd1, 8'h04, 1'b1, wr_t'{1'b0, 32'd0, 16'h0004, 8'h02}, 4'd1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 2'd1, 8'h05, 1'b1, wr_t'{1'b0, 32'd1, 16'h0005, 8'h02}, 4'd1, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 2'd1, 8'h06, 1'b0, wr_t'('0), 4'd1, 1'b1, 1'b1};
    vec[10] = '{1'b1, 2'd2, 8'hAA, 1'b0, wr_t'('0), 4'd0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 2'd2, 8'hBB, 1'b1, wr_t'{1'b1, 32'h40000, 16'hAABB, 8'h03}, 4'd0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 2'd2, 8'hCC, 1'b1, wr_t'{1'b1, 32'h40002, 16'hCC00, 8'h02}, 4'd0, 1'b1, 1'b0};
    vec[13] = '{1'b0, 2'd2, 8'hDD, 1'b0, wr_t'('0), 4'd0, 1'b1, 1'b1};
    for (int d = 0; d < 3; d++) ack_dly[d] = 0;

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs_%0d", d),
          64'({wait_v[d], bram_wr_v[d], bram_cs_v[d], req_v[d], sdr_be_v[d], idx_v[d], done_v[d], ovf_v[d]}),
          64'd0);

    for (int i = 0; i < 14; i++) begin
      if (vec[i].start) restart_all(int'(vec[i].d));
      q.delete();
      send_byte(int'(vec[i].d), vec[i].byte_in);
      $display("vec %0d dut=%0d byte=%h writes=%0d idx=%0d done=%0d ovf=%0d", i, vec[i].d,
               vec[i].byte_in, q.size(), idx_v[vec[i].d], done_v[vec[i].d], ovf_v[vec[i].d]);
      if (vec[i].exp_w) begin
        check_write($sformatf("vec%0d_write", i), vec[i].w);
      end else begin
        chk($sformatf("vec%0d_no_write", i), 64'(q.size()), 64'd0);
        q.delete();
      end
      chk($sformatf("vec%0d_region_idx", i), 64'(idx_v[vec[i].d]), 64'(vec[i].idx));
      chk($sformatf("vec%0d_load_done", i), 64'(done_v[vec[i].d]), 64'(vec[i].done));
      chk($sformatf("vec%0d_overflow", i), 64'(ovf_v[vec[i].d]), 64'(vec[i].ovf));
    end

    // New download from DONE clears status; early end flushes the pending byte.
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_load_done", 64'(done_v[2]), 64'd0);
    chk("restart_overflow", 64'(ovf_v[2]), 64'd0);
    q.delete();
    send_byte(2, 8'hAA);
    chk("pending_no_write", 64'(q.size()), 64'd0);
    ioctl_download = 1'b0;
    for (int n = 0; n < 40 && !done_v[2]; n++) @(negedge clk);
    $display("early end: done=%0d writes=%0d", done_v[2], q.size());
    chk("early_end_done", 64'(done_v[2]), 64'd1);
    check_write("early_end_flush", wr_t'{1'b1, 32'h40000, 16'hAA00, 8'h02});

    // Slow ack with a stray strobe during the stall.
    begin
      int waited;
      restart_all(1);
      ack_dly[1] = 5;
      send_byte(1, 8'h01);
      @(negedge clk);
      ioctl_dout = 8'h02;
      ioctl_wr = 1'b1;
      @(negedge clk);
      waited = 0;
      for (int i = 0; i < 40 && wait_v[1]; i++) begin
        ioctl_wr = (i == 2);
        ioctl_dout = 8'h77;
        waited++;
        @(negedge clk);
      end
      ioctl_wr = 1'b0;
      @(negedge clk);
      $display("slow ack: wait cycles=%0d writes=%0d", waited, q.size());
      chk("slow_ack_wait_ge5", 64'(waited >= 5), 64'd1);
      check_write("slow_ack_word", wr_t'{1'b1, 32'h40000, 16'h0201, 8'h03});
      send_byte(1, 8'h03);
      $display("after stall: writes=%0d idx=%0d", q.size(), idx_v[1]);
      check_write("after_stall_flush", wr_t'{1'b1, 32'h40002, 16'h0003, 8'h01});
      chk("after_stall_idx", 64'(idx_v[1]), 64'd1);
      ack_dly[1] = 0;
    end

    // Reset asserted while a write is outstanding.
    restart_all(1);
    ack_dly[1] = 30;
    send_byte(1, 8'h01);
    @(negedge clk);
    ioctl_dout = 8'h02;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    chk("inflight_req", 64'(req_v[1]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    $display("async reset: req=%0d wait=%0d idx=%0d", req_v[1], wait_v[1], idx_v[1]);
    chk("reset_drops_req", 64'({req_v[1], wait_v[1], done_v[1], idx_v[1]}), 64'd0);
    @(negedge clk);
    chk("reset_held_outputs", 64'({req_v[1], wait_v[1], bram_wr_v[1], sdr_be_v[1]}), 64'd0);
    reset_n = 1'b1;
    ack_dly[1] = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_region_loader.md
ROM_REGION_LOADER -- requirements
Module: rom_region_loader

Interface
REQ-001 SHALL have parameter N_REGIONS, default 9: number of load regions, 1..16.
REQ-002 SHALL have parameter ADDR_W, default 25: SDRAM byte-address width.
REQ-003 SHALL have parameter CS_W, default 6: BRAM chip-select width.
REQ-004 SHALL have parameter REGION_BASE, default all 0: N_REGIONS x ADDR_W packed SDRAM base addresses, even.
REQ-005 SHALL have parameter REGION_SIZE, default all 'h10000: N_REGIONS x 24 packed byte sizes, each >=1.
REQ-006 SHALL have parameter REGION_REORDER, default all 0: N_REGIONS x 1; 1 = swap bytes within 16-bit word.
REQ-007 SHALL have parameter REGION_CS, default all 0: N_REGIONS x CS_W; nonzero = BRAM region, zero = SDRAM region.
REQ-008 Ports (name direction width meaning):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download active, level
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  stall download source
- bram_wr  out  1  one-cycle BRAM write strobe
- bram_cs  out  CS_W  BRAM select
- bram_addr  out  24  byte offset inside region
- bram_data  out  8  BRAM byte
- sdr_req  out  1  SDRAM write request, level
- sdr_ack  in  1  one-cycle SDRAM write accept
- sdr_addr  out  ADDR_W  word-aligned byte address
- sdr_data  out  16  SDRAM word
- sdr_be  out  2  byte enables, bit0 = data[7:0]
- region_idx  out  4  current region
- load_done  out  1  level, all regions filled or download ended
- overflow  out  1  sticky, byte received after last region full

Function
REQ-009 SHALL implement states IDLE, LOAD, SDR_WAIT, DONE.
REQ-010 IDLE -> LOAD on ioctl_download rising edge; clears region_idx, region offset, pending half-word, load_done, overflow.
REQ-011 Regions SHALL be consumed in index order; byte stream contiguous: region k receives bytes after sum of sizes 0..k-1.
REQ-012 BRAM region byte: next cycle bram_wr=1 for exactly one cycle, bram_cs=REGION_CS[k], bram_addr=region offset, bram_data=byte; no stall.
REQ-013 SDRAM region, even offset: byte held as pending; no output.
REQ-014 SDRAM region, odd offset: next cycle sdr_req=1, sdr_addr=REGION_BASE[k]+offset-1, sdr_be=2'b11, sdr_data={odd,even} if REORDER=0 else {even,odd}; enter SDR_WAIT.
REQ-015 In SDR_WAIT ioctl_wait SHALL be 1 and sdr_addr/data/be stable; sdr_req drops the cycle after sdr_ack; return to LOAD (or DONE).
REQ-016 ioctl_wr during SDR_WAIT SHALL be ignored and not counted.
REQ-017 Offset SHALL increment per accepted byte; at offset==size-1 the region closes, region_idx increments, offset=0.
REQ-018 Odd-size SDRAM region close with pending byte SHALL flush: single write, sdr_be=2'b01 (REORDER=0) or 2'b10 (REORDER=1), other byte 0.
REQ-019 Closing region N_REGIONS-1 -> DONE after any write completes; load_done=1.
REQ-020 Bytes in DONE SHALL set overflow and produce no write.
REQ-021 ioctl_download falling in LOAD: flush pending byte per REQ-018, then DONE; falling in SDR_WAIT completes handshake first.
REQ-022 DONE -> LOAD on next ioctl_download rising edge (REQ-010).
REQ-023 ioctl_wait SHALL be 0 in IDLE, LOAD, DONE.

Reset
REQ-024 reset_n low, asynchronously: state IDLE; all outputs 0; pending byte discarded; an in-flight sdr_req dropped without waiting for sdr_ack.

Verification
REQ-025 Defaults except region0 CS=6'b000001 size 4: bytes 11,22,33,44 -> four bram_wr, addr 0..3, cs 000001, no sdr_req.
REQ-026 Region0 SDRAM base 'h40000 size 2 REORDER=0: bytes AA,BB -> sdr_addr 'h40000, data 'hBBAA, be 11; REORDER=1 -> 'hAABB.
REQ-027 sdr_ack delayed 5 cycles, ioctl_wr pulsed during wait -> ioctl_wait high 5+ cycles, extra byte ignored, offset unchanged.
REQ-028 Region0 SDRAM size 3, region1 BRAM: bytes 01,02,03,04 -> word 'h0201 be 11; word 'h0003 be 01 at base+2; bram_wr addr 0 data 04, region_idx 1.
REQ-029 All regions filled then one extra byte -> load_done=1, overflow=1, no write; reset_n low mid-SDR_WAIT -> sdr_req 0 immediately, state IDLE.
